// File: rtl/jtag_debug_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module   : jtag_debug_cmd_sync
// Brief    : Sysclk-side capture of virtual-JTAG debug commands into a
//            show-ahead queue with valid/ready handoff and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_debug_cmd_sync #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SR_W-1:0]               sr,
    input  logic [IR_W-1:0]               ir_in,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic                          cmd_ready,
    input  logic                          ovf_clr,
    output logic [SR_W-1:0]               jdo,
    output logic [IR_W-1:0]               cmd_ir,
    output logic                          cmd_valid,
    output logic [(2**IR_W)-1:0]          take_action,
    output logic [IR_W-1:0]               ir_cur,
    output logic                          ir_update,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IR_W + SR_W;

    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_prev_q, uir_prev_q;
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   ovf_q, ovf_d;
    logic [IR_W-1:0]        ir_cur_q, ir_cur_d;

    logic udr_rise, uir_rise, full, pop, push_ok, drop;

    always_comb begin
        udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
        uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        pop      = (level_q != '0) & cmd_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push_ok  = udr_rise & (~full | pop);
        drop     = udr_rise & full & ~pop;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        ir_cur_d = uir_rise ? ir_in : ir_cur_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync_q <= '0;
            uir_sync_q <= '0;
            udr_prev_q <= 1'b0;
            uir_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            ir_cur_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
            uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            ir_cur_q   <= ir_cur_d;
            // sr/ir_in are sampled raw: the TCK side holds them while the strobe is high.
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {ir_in, sr};
            end
        end
    end

    assign jdo       = mem_q[rd_ptr_q][SR_W-1:0];
    assign cmd_ir    = mem_q[rd_ptr_q][ENT_W-1:SR_W];
    assign cmd_valid = (level_q != '0);
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign ir_cur    = ir_cur_q;
    assign ir_update = uir_rise;

    always_comb begin
        take_action = '0;
        if (pop) begin
            take_action[cmd_ir] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_debug_cmd_sync
// Brief    : Directed and randomized self-checking bench for the debug
//            command capture queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_debug_cmd_sync;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] sr = '0;
    logic [1:0]  ir_in = '0;
    logic        vs_udr = 1'b0, vs_uir = 1'b0, cmd_ready = 1'b0, ovf_clr = 1'b0;
    logic [37:0] jdo;
    logic [1:0]  cmd_ir, ir_cur;
    logic        cmd_valid, ir_update, overflow;
    logic [3:0]  take_action;
    logic [2:0]  level;

    int n_total = 0;
    int n_pass  = 0;

    jtag_debug_cmd_sync #(.SR_W(38), .IR_W(2), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr),
        .vs_uir(vs_uir), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr), .jdo(jdo),
        .cmd_ir(cmd_ir), .cmd_valid(cmd_valid), .take_action(take_action),
        .ir_cur(ir_cur), .ir_update(ir_update), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic udr_pulse(input logic [37:0] s, input logic [1:0] ir, input int hi, input int lo);
        sr = s; ir_in = ir; vs_udr = 1'b1;
        repeat (hi) tick();
        vs_udr = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (cmd_valid !== 1'b0) $display("FAIL rst_valid: got %0h expected 0", cmd_valid); else n_pass++;
        n_total++; if (level !== 3'd0) $display("FAIL rst_level: got %0d expected 0", level); else n_pass++;
        n_total++; if ({overflow, ir_update, ir_cur, take_action, jdo, cmd_ir} !== '0)
            $display("FAIL rst_outs: got %0h expected 0", {overflow, ir_update, ir_cur, take_action, jdo, cmd_ir}); else n_pass++;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_capture_held();
        sr = 38'h2A_DEAD_BEEF; ir_in = 2'd2; vs_udr = 1'b1;
        tick();
        n_total++; if (cmd_valid !== 1'b0) $display("FAIL lat_k: got %0h expected 0", cmd_valid); else n_pass++;
        tick();
        n_total++; if (cmd_valid !== 1'b0) $display("FAIL lat_k1: got %0h expected 0", cmd_valid); else n_pass++;
        tick();
        n_total++; if (cmd_valid !== 1'b1) $display("FAIL lat_k2: got %0h expected 1", cmd_valid); else n_pass++;
        n_total++; if (jdo !== 38'h2A_DEAD_BEEF || cmd_ir !== 2'd2)
            $display("FAIL cap_data: got %0h/%0h expected 2adeadbeef/2", jdo, cmd_ir); else n_pass++;
        repeat (7) tick();
        n_total++; if (level !== 3'd1) $display("FAIL held_level: got %0d expected 1", level); else n_pass++;
        vs_udr = 1'b0;
        repeat (3) tick();
        cmd_ready = 1'b1;
        #1;
        n_total++; if (take_action !== 4'b0100) $display("FAIL held_act: got %b expected 0100", take_action); else n_pass++;
        tick();
        cmd_ready = 1'b0;
        n_total++; if (level !== 3'd0 || cmd_valid !== 1'b0) $display("FAIL held_pop: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_ir_update();
        ir_in = 2'd3; vs_uir = 1'b1;
        tick();
        n_total++; if (ir_update !== 1'b0) $display("FAIL uir_k: got %0h expected 0", ir_update); else n_pass++;
        tick();
        n_total++; if (ir_update !== 1'b1) $display("FAIL uir_pulse: got %0h expected 1", ir_update); else n_pass++;
        tick();
        n_total++; if (ir_update !== 1'b0) $display("FAIL uir_end: got %0h expected 0", ir_update); else n_pass++;
        n_total++; if (ir_cur !== 2'd3) $display("FAIL uir_cur: got %0d expected 3", ir_cur); else n_pass++;
        repeat (3) tick();
        vs_uir = 1'b0;
        repeat (3) tick();
        n_total++; if (level !== 3'd0 || ir_update !== 1'b0) $display("FAIL uir_fifo: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) udr_pulse(38'(i), 2'd0, 4, 3);
        n_total++; if (level !== 3'd4) $display("FAIL ovf_level: got %0d expected 4", level); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %0h expected 1", overflow); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_total++; if (jdo !== 38'(i)) $display("FAIL ovf_drain: got %0h expected %0h", jdo, i); else n_pass++;
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
        n_total++; if (cmd_valid !== 1'b0) $display("FAIL ovf_empty: got %0h expected 0", cmd_valid); else n_pass++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %0h expected 0", overflow); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 10; i <= 13; i++) udr_pulse(38'(i), 2'(i % 4), 4, 3);
        sr = 38'd14; ir_in = 2'd2; vs_udr = 1'b1;
        tick();
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_total++; if (level !== 3'd4) $display("FAIL fpp_level: got %0d expected 4", level); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL fpp_ovf: got %0h expected 0", overflow); else n_pass++;
        repeat (2) tick();
        vs_udr = 1'b0;
        repeat (3) tick();
        for (int i = 11; i <= 14; i++) begin
            n_total++; if (jdo !== 38'(i)) $display("FAIL fpp_order: got %0h expected %0h", jdo, i); else n_pass++;
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
        n_total++; if (level !== 3'd0) $display("FAIL fpp_empty: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_take_action();
        udr_pulse(38'd7, 2'd1, 4, 3);
        n_total++; if (take_action !== 4'b0000 || cmd_ir !== 2'd1)
            $display("FAIL act_idle: got %b/%0d expected 0000/1", take_action, cmd_ir); else n_pass++;
        cmd_ready = 1'b1;
        #1;
        n_total++; if (take_action !== 4'b0010) $display("FAIL act_one: got %b expected 0010", take_action); else n_pass++;
        tick();
        n_total++; if (take_action !== 4'b0000) $display("FAIL act_empty: got %b expected 0000", take_action); else n_pass++;
        tick();
        n_total++; if (level !== 3'd0 || take_action !== 4'b0000) $display("FAIL act_lvl: got %0d expected 0", level); else n_pass++;
        cmd_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [39:0] mq[$];
        logic        m_ovf;
        logic        rdy;
        logic [37:0] s;
        logic [1:0]  ir;
        int          n, budget;
        for (int it = 0; it < 8; it++) begin
            m_ovf = 1'b0;
            n = $urandom_range(1, 6);
            for (int p = 0; p < n; p++) begin
                s  = 38'({$urandom(), $urandom()});
                ir = 2'($urandom_range(0, 3));
                if (mq.size() < 4) mq.push_back({ir, s}); else m_ovf = 1'b1;
                udr_pulse(s, ir, $urandom_range(3, 5), $urandom_range(3, 5));
            end
            n_total++; if (level !== 3'(mq.size())) $display("FAIL rnd_level: got %0d expected %0d", level, mq.size()); else n_pass++;
            n_total++; if (overflow !== m_ovf) $display("FAIL rnd_ovf: got %0h expected %0h", overflow, m_ovf); else n_pass++;
            budget = 0;
            while (mq.size() > 0 && budget < 100) begin
                n_total++; if (cmd_valid !== 1'b1 || {cmd_ir, jdo} !== mq[0])
                    $display("FAIL rnd_head: got %0h expected %0h", {cmd_ir, jdo}, mq[0]); else n_pass++;
                rdy = 1'($urandom_range(0, 1));
                cmd_ready = rdy;
                #1;
                n_total++; if (take_action !== (rdy ? 4'(1 << mq[0][39:38]) : 4'b0000))
                    $display("FAIL rnd_act: got %b rdy %0d", take_action, rdy); else n_pass++;
                if (rdy) void'(mq.pop_front());
                tick();
                cmd_ready = 1'b0;
                budget++;
            end
            n_total++; if (mq.size() != 0 || cmd_valid !== 1'b0)
                $display("FAIL rnd_drain: got valid %0h left %0d expected empty", cmd_valid, mq.size()); else n_pass++;
            ovf_clr = 1'b1;
            tick();
            ovf_clr = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 20; i <= 23; i++) udr_pulse(38'(i), 2'd3, 4, 3);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_total++; if (level !== 3'd3) $display("FAIL rmid_pre: got %0d expected 3", level); else n_pass++;
        sr = 38'h55; ir_in = 2'd2; vs_udr = 1'b1;
        reset = 1'b1;
        #1;
        n_total++; if (level !== 3'd0 || cmd_valid !== 1'b0) $display("FAIL rmid_level: got %0d expected 0", level); else n_pass++;
        n_total++; if ({overflow, ir_update, ir_cur, take_action, jdo, cmd_ir} !== '0)
            $display("FAIL rmid_outs: got %0h expected 0", {overflow, ir_update, ir_cur, take_action, jdo, cmd_ir}); else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        n_total++; if (level !== 3'd1 || jdo !== 38'h55 || cmd_ir !== 2'd2)
            $display("FAIL rmid_push: got %0d/%0h/%0d expected 1/55/2", level, jdo, cmd_ir); else n_pass++;
        vs_udr = 1'b0;
        repeat (4) tick();
        n_total++; if (level !== 3'd1) $display("FAIL rmid_single: got %0d expected 1", level); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_capture_held();
        test_ir_update();
        test_overflow();
        test_full_push_pop();
        test_take_action();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
